// File: rtl/km_mul_seq_pkg.sv
// Shared definitions for the sequential Karatsuba multiplier: default width,
// FSM state encoding and the tags that identify each partial product.
package km_mul_seq_pkg;

  localparam int DATAWIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_DRAIN = 3'd2,
    ST_COMB  = 3'd3,
    ST_OUT   = 3'd4
  } state_t;

  localparam logic [1:0] TAG_Z0 = 2'd0;
  localparam logic [1:0] TAG_Z2 = 2'd1;
  localparam logic [1:0] TAG_ZS = 2'd2;

endpackage

// File: rtl/km_mul_pipe.sv
// Shared (H+1)x(H+1) unsigned multiplier with MUL_LAT output register stages;
// a valid bit and partial-product tag travel alongside each stage.
module km_mul_pipe #(
  parameter int H       = 16,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             issue_vld,
  input  logic [1:0]       issue_tag,
  input  logic [H:0]       issue_x,
  input  logic [H:0]       issue_y,
  output logic             res_vld,
  output logic [1:0]       res_tag,
  output logic [2*H+1:0]   res_prod
);

  logic [2*H+1:0] prod_comb;

  assign prod_comb = {{(H+1){1'b0}}, issue_x} * {{(H+1){1'b0}}, issue_y};

  if (MUL_LAT == 0) begin : g_comb
    assign res_vld  = issue_vld;
    assign res_tag  = issue_tag;
    assign res_prod = prod_comb;
  end else begin : g_reg
    logic [2*H+1:0] prod_p [MUL_LAT];
    logic [1:0]     tag_p  [MUL_LAT];
    logic [MUL_LAT-1:0] vld_p;

    // stage boundary: product, tag and valid shift together
    always_ff @(posedge clk) begin
      if (!rstn) begin
        vld_p <= '0;
        for (int i = 0; i < MUL_LAT; i++) begin
          prod_p[i] <= '0;
          tag_p[i]  <= '0;
        end
      end else begin
        vld_p[0]  <= issue_vld;
        tag_p[0]  <= issue_tag;
        prod_p[0] <= prod_comb;
        for (int i = 1; i < MUL_LAT; i++) begin
          vld_p[i]  <= vld_p[i-1];
          tag_p[i]  <= tag_p[i-1];
          prod_p[i] <= prod_p[i-1];
        end
      end
    end

    assign res_vld  = vld_p[MUL_LAT-1];
    assign res_tag  = tag_p[MUL_LAT-1];
    assign res_prod = prod_p[MUL_LAT-1];
  end

endmodule

// File: rtl/km_mul_seq.sv
// Sequential Karatsuba multiplier: one shared half-width multiplier issues
// z0, z2 and zs over three cycles, then a registered recombination.
module km_mul_seq
  import km_mul_seq_pkg::*;
#(
  parameter int DW      = DATAWIDTH,
  parameter int MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_half,
  input  logic [DW-1:0]   in_a,
  input  logic [DW-1:0]   in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*DW-1:0] out_p
);

  localparam int H = DW / 2;

  state_t          state, state_nxt;
  logic [DW-1:0]   a_q, b_q;
  logic            half_q;
  logic [1:0]      cnt;
  logic [2:0]      drain_cnt;
  logic [2*H-1:0]  z0_q, z2_q;
  logic [2*H+1:0]  zs_q;

  logic            issue_vld;
  logic [H:0]      issue_x, issue_y;
  logic            res_vld;
  logic [1:0]      res_tag;
  logic [2*H+1:0]  res_prod;

  logic [2*H+1:0]  z1;
  logic [2*DW-1:0] recomb;

  assign in_ready  = (state == ST_IDLE) && rstn;
  assign out_valid = (state == ST_OUT);
  assign issue_vld = (state == ST_ISSUE);

  // Issue order follows the tag encoding: cnt 0 -> z0, 1 -> z2, 2 -> zs.
  always_comb begin
    issue_x = {1'b0, a_q[H-1:0]};
    issue_y = {1'b0, b_q[H-1:0]};
    if (cnt == TAG_Z2) begin
      issue_x = {1'b0, a_q[DW-1:H]};
      issue_y = {1'b0, b_q[DW-1:H]};
    end else if (cnt == TAG_ZS) begin
      issue_x = {1'b0, a_q[H-1:0]} + {1'b0, a_q[DW-1:H]};
      issue_y = {1'b0, b_q[H-1:0]} + {1'b0, b_q[DW-1:H]};
    end
  end

  km_mul_pipe #(.H(H), .MUL_LAT(MUL_LAT)) u_pipe (
    .clk       (clk),
    .rstn      (rstn),
    .issue_vld (issue_vld),
    .issue_tag (cnt),
    .issue_x   (issue_x),
    .issue_y   (issue_y),
    .res_vld   (res_vld),
    .res_tag   (res_tag),
    .res_prod  (res_prod)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (in_valid) state_nxt = ST_ISSUE;
      ST_ISSUE: if (half_q || cnt == 2'd2)
                  state_nxt = (MUL_LAT > 0) ? ST_DRAIN : ST_COMB;
      ST_DRAIN: if (drain_cnt == 3'(MUL_LAT - 1)) state_nxt = ST_COMB;
      ST_COMB:  state_nxt = ST_OUT;
      ST_OUT:   if (out_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // z1 is non-negative and the sum wraps modulo 2^(2*DW) without loss.
  assign z1     = zs_q - {2'b00, z0_q} - {2'b00, z2_q};
  assign recomb = {z2_q, {DW{1'b0}}}
                + {{(H-2){1'b0}}, z1, {H{1'b0}}}
                + {{DW{1'b0}}, z0_q};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      a_q       <= '0;
      b_q       <= '0;
      half_q    <= 1'b0;
      cnt       <= '0;
      drain_cnt <= '0;
      z0_q      <= '0;
      z2_q      <= '0;
      zs_q      <= '0;
      out_p     <= '0;
    end else begin
      if (state == ST_IDLE && in_valid) begin
        a_q    <= in_a;
        b_q    <= in_b;
        half_q <= in_half;
        cnt    <= '0;
      end else if (state == ST_ISSUE) begin
        cnt <= cnt + 2'd1;
      end
      drain_cnt <= (state == ST_DRAIN) ? drain_cnt + 3'd1 : 3'd0;
      if (res_vld) begin
        case (res_tag)
          TAG_Z0:  z0_q <= res_prod[2*H-1:0];
          TAG_Z2:  z2_q <= res_prod[2*H-1:0];
          default: zs_q <= res_prod;
        endcase
      end
      if (state == ST_COMB)
        out_p <= half_q ? {{DW{1'b0}}, z0_q} : recomb;
    end
  end

endmodule

// File: tb/tb_km_mul_seq.sv
// Scoreboard bench: three instances (MUL_LAT 0, 2, 4) share stimulus; each
// instance has its own expectation queue and monitor.
module tb_km_mul_seq;

  typedef struct {
    logic [63:0] p;
    int          t0;
    logic        half;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_half = 1'b0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        out_ready = 1'b1;
  logic        ov [3];
  logic        ir [3];
  logic [63:0] op [3];

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int LAT = 2 * k;
    exp_t q[$];
    logic prev_v = 1'b0;
    logic prev_hs = 1'b0;
    logic [63:0] prev_p = '0;

    km_mul_seq #(.DW(32), .MUL_LAT(LAT)) u_dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .in_ready  (ir[k]),
      .in_half   (in_half),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (ov[k]),
      .out_ready (out_ready),
      .out_p     (op[k])
    );

    always @(negedge clk) begin
      #3;
      if (!rstn) begin
        prev_v  = 1'b0;
        prev_hs = 1'b0;
      end else begin
        if (prev_hs) chk($sformatf("valid_drop_L%0d", LAT), 64'(ov[k]), 64'd0);
        if (prev_v && !prev_hs) begin
          chk($sformatf("hold_valid_L%0d", LAT), 64'(ov[k]), 64'd1);
          chk($sformatf("hold_p_L%0d", LAT), op[k], prev_p);
        end
        if (ov[k]) begin
          chk($sformatf("ready_busy_L%0d", LAT), 64'(ir[k]), 64'd0);
          if (!prev_v || prev_hs) begin
            if (q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL stale_result_L%0d: got 0x%0h with no operation pending", LAT, op[k]);
            end else begin
              chk($sformatf("latency_L%0d", LAT), 64'(cyc),
                  64'(q[0].t0 + LAT + (q[0].half ? 2 : 4)));
              chk($sformatf("product_L%0d", LAT), op[k], q[0].p);
            end
          end
          if (out_ready && q.size() != 0) void'(q.pop_front());
        end
        prev_v  = ov[k];
        prev_hs = ov[k] && out_ready;
        prev_p  = op[k];
      end
    end
  end

  function automatic logic all_ready();
    return ir[0] && ir[1] && ir[2];
  endfunction

  function automatic logic all_empty();
    return g_dut[0].q.size() == 0 && g_dut[1].q.size() == 0 && g_dut[2].q.size() == 0;
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic h,
                       input logic [63:0] p);
    exp_t e;
    int n = 0;
    while (!all_ready() && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) timeout_fail("issue_wait_ready");
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_half  = h;
    e.p = p;
    e.t0 = cyc + 1;
    e.half = h;
    g_dut[0].q.push_back(e);
    g_dut[1].q.push_back(e);
    g_dut[2].q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = 32'hA5A5_5A5A;
    in_b     = 32'h5A5A_A5A5;
    in_half  = ~h;
    #1;
    for (int i = 0; i < 3; i++) chk("busy_after_accept", 64'(ir[i]), 64'd0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!all_empty() && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) timeout_fail("wait_done");
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // reset state
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_in_ready", 64'(ir[i]), 64'd0);
      chk("rst_out_valid", 64'(ov[i]), 64'd0);
      chk("rst_out_p", op[i], 64'd0);
    end
    @(negedge clk);
    rstn = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) chk("ready_after_rst", 64'(ir[i]), 64'd1);

    // maximum operands, cross terms, general, half mode
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
    wait_done();
    issue(32'h0001_0000, 32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000);
    wait_done();
    issue(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 64'h0B00_EA4E_242D_2080);
    wait_done();
    issue(32'h1234_FFFF, 32'hABCD_0002, 1'b1, 64'h0000_0000_0001_FFFE);
    wait_done();

    // backpressure with a new request waiting
    out_ready = 1'b0;
    issue(32'h0000_FFFF, 32'h0001_0001, 1'b0, 64'h0000_0000_FFFF_FFFF);
    n = 0;
    while (!(ov[0] && ov[1] && ov[2]) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) timeout_fail("bp_wait_valid");
    in_valid = 1'b1;
    in_a = 32'd3;
    in_b = 32'd5;
    repeat (5) begin
      @(negedge clk);
      #1;
      for (int i = 0; i < 3; i++) chk("bp_in_ready", 64'(ir[i]), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    issue(32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F);
    wait_done();

    // reset in the middle of an operation
    issue(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 64'h0B00_EA4E_242D_2080);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;
    g_dut[0].q.delete();
    g_dut[1].q.delete();
    g_dut[2].q.delete();
    #1;
    for (int i = 0; i < 3; i++) chk("midrst_in_ready", 64'(ir[i]), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("midrst_out_valid", 64'(ov[i]), 64'd0);
      chk("midrst_out_p", op[i], 64'd0);
      chk("midrst_in_ready_rel", 64'(ir[i]), 64'd1);
    end
    issue(32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 64'd0);
    wait_done();
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
